// File: rtl/lsu_align_if.sv
// Request/response and data-bus signal bundle for lsu_align.
// slave = the alignment unit, master = execute stage plus bus fabric.
interface lsu_align_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [XLEN-1:0]   resp_rdata;
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_wr;
    logic [ADDR_W-1:0] bus_addr;
    logic [NB-1:0]     bus_wstrb;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_rvalid;
    logic [XLEN-1:0]   bus_rdata;

    modport slave (
        input  req_valid, req_wr, req_addr, req_size, req_signed, req_wdata,
        input  bus_ready, bus_rvalid, bus_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output bus_valid, bus_wr, bus_addr, bus_wstrb, bus_wdata
    );

    modport master (
        output req_valid, req_wr, req_addr, req_size, req_signed, req_wdata,
        output bus_ready, bus_rvalid, bus_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  bus_valid, bus_wr, bus_addr, bus_wstrb, bus_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: one access per request, aligned bus beats with strobes, load merge/extend.
// Optional macro LSU_MISALIGN_SPLIT_EN: split word-crossing accesses into two beats (else they error).
module lsu_align #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input logic        clk,
    input logic        rst_n,
    lsu_align_if.slave io
);
    localparam int NB = XLEN / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_R0   = 3'd2,
        S_B1   = 3'd3,
        S_R1   = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_wr;
    logic              r_signed;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata0;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic              r_cross;
    logic [XLEN-1:0]   r_rdata1;
    logic [2*NB-1:0]   w_strb2;
    logic [2*XLEN-1:0] w_wdata2;
`else
    logic [NB-1:0]     w_strb0;
    logic [XLEN-1:0]   w_wdata0;
`endif

    logic              w_accept;
    logic [OB-1:0]     w_req_off;
    logic [4:0]        w_req_bytes;
    logic              w_req_cross;
    logic              w_req_illegal;
    logic              w_req_err;
    logic [OB-1:0]     w_off;
    logic [OB+2:0]     w_shift;
    logic [ADDR_W-1:0] w_base;
    logic [NB-1:0]     w_mask;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_merged;

    function automatic logic [NB-1:0] f_byte_mask(input logic [1:0] size);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[i] = (i < (1 << size));
        end
        return m;
    endfunction

    // Zero (or sign-fill) every byte above the access size.
    function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] t,
                                                 input logic [1:0]      size,
                                                 input logic            sgn);
        logic [XLEN-1:0] res;
        logic [NB-1:0]   m;
        logic            sb;
        m = f_byte_mask(size);
        case (size)
            2'd0:    sb = t[7];
            2'd1:    sb = t[15];
            2'd2:    sb = t[31];
            default: sb = t[XLEN-1];
        endcase
        for (int i = 0; i < NB; i++) begin
            res[8*i +: 8] = m[i] ? t[8*i +: 8] : {8{sgn & sb}};
        end
        return res;
    endfunction

    assign w_accept      = io.req_valid && (r_state == S_IDLE);
    assign w_req_off     = io.req_addr[OB-1:0];
    assign w_req_bytes   = 5'd1 << io.req_size;
    assign w_req_cross   = (5'(w_req_off) + w_req_bytes) > 5'(NB);
    assign w_req_illegal = {1'b0, io.req_size} > 3'(OB);
`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_req_err     = w_req_illegal;
`else
    assign w_req_err     = w_req_illegal || w_req_cross;
`endif

    assign w_off   = r_addr[OB-1:0];
    assign w_shift = {w_off, 3'b000};
    assign w_base  = {r_addr[ADDR_W-1:OB], {OB{1'b0}}};
    assign w_mask  = f_byte_mask(r_size);
`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_strb2   = {{NB{1'b0}}, w_mask} << w_off;
    assign w_wdata2  = {{XLEN{1'b0}}, r_wdata} << w_shift;
    assign w_shifted = XLEN'({r_rdata1, r_rdata0} >> w_shift);
`else
    assign w_strb0   = w_mask << w_off;
    assign w_wdata0  = r_wdata << w_shift;
    assign w_shifted = r_rdata0 >> w_shift;
`endif
    assign w_merged = f_extend(w_shifted, r_size, r_signed);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = w_req_err ? S_RESP : S_B0;
                else          w_next = S_IDLE;
            end
            S_B0: begin
                if (!io.bus_ready) w_next = S_B0;
                else if (!r_wr)    w_next = S_R0;
`ifdef LSU_MISALIGN_SPLIT_EN
                else               w_next = r_cross ? S_B1 : S_RESP;
`else
                else               w_next = S_RESP;
`endif
            end
            S_R0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (io.bus_rvalid) w_next = r_cross ? S_B1 : S_RESP;
`else
                if (io.bus_rvalid) w_next = S_RESP;
`endif
                else               w_next = S_R0;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_B1: begin
                if (!io.bus_ready) w_next = S_B1;
                else               w_next = r_wr ? S_RESP : S_R1;
            end
            S_R1: begin
                if (io.bus_rvalid) w_next = S_RESP;
                else               w_next = S_R1;
            end
`endif
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch and read-data capture; stale read data is cleared on every accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr     <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= {ADDR_W{1'b0}};
            r_size   <= 2'd0;
            r_wdata  <= {XLEN{1'b0}};
            r_rdata0 <= {XLEN{1'b0}};
`ifdef LSU_MISALIGN_SPLIT_EN
            r_cross  <= 1'b0;
            r_rdata1 <= {XLEN{1'b0}};
`endif
        end else if (w_accept) begin
            r_wr     <= io.req_wr;
            r_signed <= io.req_signed;
            r_err    <= w_req_err;
            r_addr   <= io.req_addr;
            r_size   <= io.req_size;
            r_wdata  <= io.req_wdata;
            r_rdata0 <= {XLEN{1'b0}};
`ifdef LSU_MISALIGN_SPLIT_EN
            r_cross  <= w_req_cross;
            r_rdata1 <= {XLEN{1'b0}};
`endif
        end else if ((r_state == S_R0) && io.bus_rvalid) begin
            r_rdata0 <= io.bus_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        end else if ((r_state == S_R1) && io.bus_rvalid) begin
            r_rdata1 <= io.bus_rdata;
`endif
        end
    end

    // Outputs decoded from state and latched request only, so they hold steady under backpressure.
    always_comb begin
        io.req_ready  = (r_state == S_IDLE);
        io.resp_valid = 1'b0;
        io.resp_err   = 1'b0;
        io.resp_rdata = {XLEN{1'b0}};
        io.bus_valid  = 1'b0;
        io.bus_wr     = 1'b0;
        io.bus_addr   = {ADDR_W{1'b0}};
        io.bus_wstrb  = {NB{1'b0}};
        io.bus_wdata  = {XLEN{1'b0}};
        case (r_state)
            S_B0: begin
                io.bus_valid = 1'b1;
                io.bus_wr    = r_wr;
                io.bus_addr  = w_base;
`ifdef LSU_MISALIGN_SPLIT_EN
                io.bus_wstrb = w_strb2[NB-1:0];
                io.bus_wdata = w_wdata2[XLEN-1:0];
`else
                io.bus_wstrb = w_strb0;
                io.bus_wdata = w_wdata0;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            S_B1: begin
                io.bus_valid = 1'b1;
                io.bus_wr    = r_wr;
                io.bus_addr  = w_base + ADDR_W'(NB);
                io.bus_wstrb = w_strb2[2*NB-1:NB];
                io.bus_wdata = w_wdata2[2*XLEN-1:XLEN];
            end
`endif
            S_RESP: begin
                io.resp_valid = 1'b1;
                io.resp_err   = r_err;
                if (r_wr || r_err) io.resp_rdata = {XLEN{1'b0}};
                else               io.resp_rdata = w_merged;
            end
            default: begin
                io.resp_valid = 1'b0;
            end
        endcase
    end
endmodule
